// File: rtl/relu_serializer.sv
// relu_serializer: unpacks one array_size-lane activation vector per handshake into a word stream with running write addresses
//   params : data_width (bits/lane), array_size (lanes/vector), addr_width (address counter width)
//   ports  : clk, rst_n (sync, active-low)
//            in_valid/in_ready/in_data  packed vector input, lane 0 in the LSBs
//            addr_clr                   synchronous clear of the address counter
//            out_valid/out_ready/out_data/out_addr/out_last  word stream
//            busy                       a vector is held
//   option : ACT_ZERO_SKIP_EN  zero lanes retire without being emitted (address still advances)
module relu_serializer #(
    parameter int data_width = 8,
    parameter int array_size = 8,
    parameter int addr_width = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [data_width*array_size-1:0] in_data,
    input  logic                             addr_clr,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [data_width-1:0]            out_data,
    output logic [addr_width-1:0]            out_addr,
    output logic                             out_last,
    output logic                             busy
);
    localparam int lw = array_size > 1 ? $clog2(array_size) : 1;
    typedef enum logic {idle, shift} state_t;
    state_t state, state_nx;
    logic [data_width*array_size-1:0] vec;
    logic [lw-1:0] lane;
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] word;
    logic last, skip, retire, accept;
    assign word = vec[lane*data_width +: data_width];
    assign last = lane == lw'(array_size - 1);
`ifdef ACT_ZERO_SKIP_EN
    assign skip = busy && word == '0;
`else
    assign skip = 1'b0;
`endif
    assign busy      = state == shift;
    assign out_valid = busy && !skip;
    // a skipped lane retires regardless of out_ready
    assign retire    = busy && (skip || out_ready);
    assign in_ready  = rst_n && (!busy || (retire && last));
    assign accept    = in_valid && in_ready;
    assign out_data  = busy ? word : '0;
    assign out_addr  = addr;
    assign out_last  = out_valid && last;
    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = shift;
        else if (retire && last)
            state_nx = idle;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= idle;
            lane  <= '0;
            addr  <= '0;
            vec   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                vec  <= in_data;
                lane <= '0;
            end else if (retire) begin
                lane <= last ? '0 : lane + 1'b1;
            end
            // clear wins over increment; the word in flight already shows its old address
            if (addr_clr)
                addr <= '0;
            else if (retire)
                addr <= addr + 1'b1;
        end
    end
endmodule

// File: tb/tb_relu_serializer.sv
// tb_relu_serializer: table-driven per-cycle check of relu_serializer
module tb_relu_serializer;
    localparam int dw = 8;
    localparam int as = 8;
    localparam int aw = 4;
    localparam logic [63:0] v1   = 64'h0807060504030201;
    localparam logic [63:0] v2   = 64'h1817161514131211;
    localparam logic [63:0] v3   = 64'h2827262524232221;
    localparam logic [63:0] v4   = 64'h3837363534333231;
    localparam logic [63:0] v5   = 64'h0000000300000001;
    localparam logic [63:0] junk = 64'hdeadbeefcafef00d;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [dw*as-1:0] in_data = '0;
    logic addr_clr = 1'b0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [dw-1:0] out_data;
    logic [aw-1:0] out_addr;
    logic out_last;
    logic busy;
    int pass_cnt = 0;
    int total = 0;
    always #5 clk = ~clk;
    relu_serializer #(.data_width(dw), .array_size(as), .addr_width(aw)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy)
    );
    typedef struct {
        logic r, iv, c, o, ev, el, eir, eb;
        logic [63:0] d;
        logic [7:0] ed;
        logic [3:0] ea;
    } row_t;
    row_t tv[$];
    function automatic void add(input logic r, iv, input logic [63:0] d, input logic c, o, ev,
                                input logic [7:0] ed, input logic [3:0] ea, input logic el, eir, eb);
        row_t x;
        x.r = r; x.iv = iv; x.d = d; x.c = c; x.o = o;
        x.ev = ev; x.ed = ed; x.ea = ea; x.el = el; x.eir = eir; x.eb = eb;
        tv.push_back(x);
    endfunction
    function automatic logic [7:0] lb(input logic [63:0] v, input int k);
        return v[k*8 +: 8];
    endfunction
    function automatic logic vis(input logic [63:0] v, input int k);
`ifdef ACT_ZERO_SKIP_EN
        return lb(v, k) != 8'h0;
`else
        return 1'b1;
`endif
    endfunction
    function automatic void idle_row(input logic iv, input logic [63:0] d, input logic [3:0] a);
        add(1'b1, iv, d, 1'b0, 1'b1, 1'b0, 8'h0, a, 1'b0, 1'b1, 1'b0);
    endfunction
    // full vector with out_ready high; nx_iv/nx_d drive the last-lane cycle, mid_iv the others
    function automatic void lanes(input logic [63:0] v, input int a0, input logic nx_iv,
                                  input logic [63:0] nx_d, input logic mid_iv);
        for (int k = 0; k < 8; k++)
            add(1'b1, k == 7 ? nx_iv : mid_iv, k == 7 ? nx_d : junk, 1'b0, 1'b1, vis(v, k), lb(v, k),
                4'(a0 + k), k == 7 && vis(v, k), k == 7, 1'b1);
    endfunction
    task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s row %0d: got %0h want %0h", name, i, act, exp);
    endtask
    initial begin
        idle_row(1'b0, '0, 4'd0);
        idle_row(1'b1, v1, 4'd0);
        lanes(v1, 0, 1'b0, '0, 1'b0);
        idle_row(1'b0, '0, 4'd8);
        idle_row(1'b1, v2, 4'd8);
        lanes(v2, 8, 1'b1, v3, 1'b1);
        lanes(v3, 16, 1'b0, '0, 1'b0);
        idle_row(1'b0, '0, 4'd8);
        idle_row(1'b1, v4, 4'd8);
        for (int k = 0; k < 8; k++) begin
            if (k > 0)
                repeat (2) add(1'b1, 1'b1, junk, 1'b0, 1'b0, 1'b1, lb(v4, k), 4'(8 + k), k == 7, 1'b0, 1'b1);
            add(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, lb(v4, k), 4'(8 + k), k == 7, k == 7, 1'b1);
        end
        idle_row(1'b0, '0, 4'd0);
        idle_row(1'b1, v1, 4'd0);
        for (int k = 0; k < 8; k++)
            add(1'b1, 1'b0, '0, k == 5, 1'b1, 1'b1, lb(v1, k), 4'(k <= 5 ? k : k - 6), k == 7, k == 7, 1'b1);
        idle_row(1'b0, '0, 4'd2);
        idle_row(1'b1, v2, 4'd2);
        for (int k = 0; k < 3; k++)
            add(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, lb(v2, k), 4'(2 + k), 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, junk, 1'b0, 1'b1, 1'b1, 8'h14, 4'd5, 1'b0, 1'b0, 1'b1);
        idle_row(1'b0, '0, 4'd0);
        idle_row(1'b1, v1, 4'd0);
        lanes(v1, 0, 1'b0, '0, 1'b0);
        idle_row(1'b1, v5, 4'd8);
        lanes(v5, 8, 1'b0, '0, 1'b0);
        idle_row(1'b1, v1, 4'd0);
        lanes(v1, 0, 1'b0, '0, 1'b0);
        idle_row(1'b0, '0, 4'd8);
        repeat (2) @(posedge clk);
        foreach (tv[i]) begin
            @(negedge clk);
            rst_n     = tv[i].r;
            in_valid  = tv[i].iv;
            in_data   = tv[i].d;
            addr_clr  = tv[i].c;
            out_ready = tv[i].o;
            #1;
            chk("out_valid", i, 64'(out_valid), 64'(tv[i].ev));
            chk("out_data", i, 64'(out_data), 64'(tv[i].ed));
            chk("out_addr", i, 64'(out_addr), 64'(tv[i].ea));
            chk("out_last", i, 64'(out_last), 64'(tv[i].el));
            chk("in_ready", i, 64'(in_ready), 64'(tv[i].eir));
            chk("busy", i, 64'(busy), 64'(tv[i].eb));
        end
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
